arb_mux_stage: RTL and testbench



---
 rtl/arb_mux_stage.sv | 166 ++++++++++++++++
 tb/tb_arb_mux_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_stage.sv
// Buffered N-input merge stage: per-stream FIFOs feed an external arbiter, granted head goes to a registered output.
// Define ARB_MUX_STAGE_PKT_LOCK_EN to keep multi-beat packets from one source contiguous at the output.
module arb_mux_stage #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N-1:0]                        in_valid,
  output logic [N-1:0]                        in_ready,
  input  logic [N*W-1:0]                      in_data,
  input  logic [N-1:0]                        in_last,
  output logic [N-1:0]                        arb_req,
  input  logic [N-1:0]                        arb_gnt,
  output logic                                arb_enable,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [W-1:0]                        out_data,
  output logic                                out_last,
  output logic [$clog2((N > 1) ? N : 2)-1:0]  out_src
);

  localparam int unsigned SW = $clog2((N > 1) ? N : 2);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = W + 1;

  logic [EW-1:0] mem_q  [N][DEPTH];
  logic [EW-1:0] mem_d  [N][DEPTH];
  logic [PW-1:0] wptr_q [N];
  logic [PW-1:0] wptr_d [N];
  logic [PW-1:0] rptr_q [N];
  logic [PW-1:0] rptr_d [N];
  logic [CW-1:0] cnt_q  [N];
  logic [CW-1:0] cnt_d  [N];

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic          out_last_q,  out_last_d;
  logic [SW-1:0] out_src_q,   out_src_d;

  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic [N-1:0]  hit;
  logic [N-1:0]  first_hit;
  logic          pop_en;
  logic [SW-1:0] sel;
  logic [EW-1:0] head;

`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
  logic          in_pkt_q, in_pkt_d;
  logic [SW-1:0] owner_q,  owner_d;
`endif

  // FIFO status and arbiter request; a locked packet masks every other source
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = (cnt_q[i] != CW'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
      arb_req[i]  = (cnt_q[i] != '0) & (!in_pkt_q | (owner_q == SW'(i)));
`else
      arb_req[i]  = (cnt_q[i] != '0);
`endif
    end
    arb_enable = !out_valid_q | out_ready;
    hit        = arb_gnt & arb_req;
  end

  // Lowest granted requester wins even if the arbiter hands back a multi-hot grant
  always_comb begin
    first_hit = '0;
    sel       = '0;
    head      = '0;
    for (int i = 0; i < N; i++) begin
      if (hit[i] && (first_hit == '0)) begin
        first_hit[i] = 1'b1;
        sel          = SW'(i);
        head         = mem_q[i][rptr_q[i]];
      end
    end
    pop_en = arb_enable & (|hit);
    pop    = pop_en ? first_hit : '0;
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < N; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = {in_last[i], in_data[i*W +: W]};
        wptr_d[i]           = wptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rptr_d[i] = rptr_q[i] + PW'(1);
      end
    end
  end

  // Output register loads on every pop, so a drain and a new pop chain without a bubble
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
    in_pkt_d    = in_pkt_q;
    owner_d     = owner_q;
`endif
    if (pop_en) begin
      out_valid_d = 1'b1;
      out_data_d  = head[W-1:0];
      out_last_d  = head[W];
      out_src_d   = sel;
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
      in_pkt_d    = !head[W];
      if (!head[W]) begin
        owner_d = sel;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q      <= '{default: '0};
      rptr_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
      in_pkt_q    <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
      in_pkt_q    <= in_pkt_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_stage.sv
// Bench for arb_mux_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_arb_mux_stage;

  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DEPTH = 2;
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   arb_gnt;
  logic           arb_enable;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [0:0]     out_src;

  logic           gnt_rand;
  logic [N-1:0]   rand_gnt;
  int             rr_ptr;
  logic [N-1:0]   tb_hit;
  logic           hit_any;
  int             hit_idx;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W:0]   mq [N][$];
  bit           m_ov;
  logic [W-1:0] m_od;
  bit           m_ol;
  int           m_os;
  bit           m_pkt;
  int           m_own;

  arb_mux_stage #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_enable(arb_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter environment, or raw random grants to exercise multi-hot handling
  always_comb begin
    arb_gnt = '0;
    if (gnt_rand) begin
      arb_gnt = rand_gnt;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (arb_req[(rr_ptr + k) % N]) begin
          arb_gnt = '0;
          arb_gnt[(rr_ptr + k) % N] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tb_hit  = arb_gnt & arb_req;
    hit_any = |tb_hit;
    hit_idx = 0;
    for (int i = N - 1; i >= 0; i--) if (tb_hit[i]) hit_idx = i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr <= 0;
    else if (arb_enable && hit_any) rr_ptr <= (hit_idx + 1) % N;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (mq[i].size() != 0) && (!LOCK_EN || !m_pkt || (m_own == i));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_pkt = 0; m_own = 0;
  endtask

  task automatic check_model();
    for (int i = 0; i < N; i++) check_eq("in_ready", in_ready[i], mq[i].size() != DEPTH);
    check_eq("arb_req", arb_req, model_req());
    check_eq("arb_enable", arb_enable, !m_ov || out_ready);
    check_eq("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check_eq("out_data", out_data, m_od);
      check_eq("out_last", out_last, m_ol);
      check_eq("out_src", out_src, m_os);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs now applied
  task automatic update_model();
    int sz [N];
    logic [N-1:0] h;
    logic [W:0] b;
    int s;
    for (int i = 0; i < N; i++) sz[i] = mq[i].size();
    h = arb_gnt & model_req();
    if ((!m_ov || out_ready) && (h != '0)) begin
      s = 0;
      for (int i = N - 1; i >= 0; i--) if (h[i]) s = i;
      b = mq[s].pop_front();
      m_ov = 1; m_od = b[W-1:0]; m_ol = b[W]; m_os = s;
      if (LOCK_EN) begin
        if (!b[W]) begin m_pkt = 1; m_own = s; end
        else m_pkt = 0;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int i = 0; i < N; i++)
      if (in_valid[i] && sz[i] < DEPTH) mq[i].push_back({in_last[i], in_data[i*W +: W]});
  endtask

  task automatic step();
    #1;
    check_model();
    update_model();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [N-1:0] l, input logic ordy);
    in_valid  = v;
    in_data   = {d1, d0};
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    gnt_rand = 1'b0;
    rand_gnt = '0;
    drive('0, '0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 2'b11);
    check_eq("rst_arb_req", arb_req, 2'b00);
    check_eq("rst_arb_enable", arb_enable, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_out_src", out_src, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [W-1:0] t2_beats [4];
  int           srcs [$];
  int           exp_src [4];

  initial begin
    t2_beats = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
    apply_reset();

    // Single beat on stream 1: request one cycle after push, output one cycle later
    drive(2'b10, '0, 32'hA5A5_A5A5, 2'b10, 1'b1);
    step();
    drive('0, '0, '0, '0, 1'b1);
    check_eq("t1_req_c1", arb_req, 2'b10);
    step();
    check_eq("t1_ov_c2", out_valid, 1'b1);
    check_eq("t1_data_c2", out_data, 32'hA5A5_A5A5);
    check_eq("t1_src_c2", out_src, 1'b1);
    check_eq("t1_last_c2", out_last, 1'b1);
    step();
    check_eq("t1_ov_c3", out_valid, 1'b0);

    // Back-pressure: output holds beat 1, FIFO 0 fills with beats 2 and 3, beat 4 refused
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, t2_beats[(k < 3) ? k : 3], '0, 2'b00, 1'b0);
      if (k >= 3) begin
        check_eq("t2_full", in_ready[0], 1'b0);
        check_eq("t2_hold", out_data, t2_beats[0]);
      end
      step();
    end
    drive('0, '0, '0, '0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      check_eq("t2_drain_ov", out_valid, 1'b1);
      check_eq("t2_drain_data", out_data, t2_beats[j]);
      step();
    end
    check_eq("t2_empty", out_valid, 1'b0);

    // Both streams saturated with an alternating arbiter
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      drive(2'b11, 32'h3000_0000 + k, 32'h3100_0000 + k, 2'b11, 1'b1);
      step();
      if (k + 1 >= 2) begin
        check_eq("t3_ov", out_valid, 1'b1);
        check_eq("t3_src", out_src, (k + 1) % 2);
      end
    end

    // Three-beat packet on stream 0 with a gap, stream 1 always valid
    apply_reset();
    srcs.delete();
    for (int k = 0; k < 10; k++) begin
      drive({1'b1, (k == 0 || k == 2 || k == 3)}, 32'h4000_0000 + k, 32'h4100_0000 + k,
            {1'b1, (k == 3)}, 1'b1);
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
      if (k == 2) check_eq("t4_gap_req", arb_req, 2'b00);
`else
      if (k == 2) check_eq("t4_gap_req", arb_req, 2'b10);
`endif
      step();
      if (out_valid) srcs.push_back(int'(out_src));
    end
`ifdef ARB_MUX_STAGE_PKT_LOCK_EN
    exp_src = '{0, 0, 0, 1};
`else
    exp_src = '{0, 1, 0, 1};
`endif
    check_eq("t4_nbeats", srcs.size() >= 4, 1'b1);
    for (int j = 0; j < 4; j++)
      if (j < srcs.size()) check_eq("t4_src_seq", srcs[j], exp_src[j]);

    // Asynchronous reset while holding data
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h5000_0000 + k, 32'h5100_0000 + k, 2'b11, 1'b0);
      step();
    end
    check_eq("t5_pre_ov", out_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t5_async_ov", out_valid, 1'b0);
    check_eq("t5_async_ready", in_ready, 2'b11);
    check_eq("t5_async_req", arb_req, 2'b00);
    model_reset();
    drive('0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("t5_rel_ready", in_ready, 2'b11);
    check_eq("t5_rel_req", arb_req, 2'b00);
    @(negedge clk);

    // Random traffic, back-pressure and grant patterns against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) gnt_rand = 1'($urandom_range(1));
      rand_gnt = N'($urandom);
      drive(N'($urandom), $urandom, $urandom,
            {($urandom_range(2) == 0), ($urandom_range(2) == 0)}, ($urandom_range(3) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
